// File: rtl/neuro_datapath.sv
// Single-issue fixed-point execution unit for neuroevolution threads: add/sub/mul,
// activations, and LFSR-based random/mutation ops, with one-cycle finished pulse.
module neuro_datapath #(
  parameter int unsigned W       = 16,
  parameter int unsigned FRAC    = 8,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int unsigned INSTR_W = 2 * W + 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [INSTR_W-1:0] instruction_dp,
  input  logic               start_dp,
  output logic [W-1:0]       result_dp,
  output logic               finished_dp,
  output logic               busy
);

  localparam logic [3:0] OpNop    = 4'd0;
  localparam logic [3:0] OpAdd    = 4'd1;
  localparam logic [3:0] OpSub    = 4'd2;
  localparam logic [3:0] OpMul    = 4'd3;
  localparam logic [3:0] OpMax    = 4'd4;
  localparam logic [3:0] OpRelu   = 4'd5;
  localparam logic [3:0] OpSigm   = 4'd6;
  localparam logic [3:0] OpRand   = 4'd7;
  localparam logic [3:0] OpMutate = 4'd8;

  localparam int unsigned CntW = $clog2(W + 1);

  // Extended-width (W+2) signed limits for saturation and sigmoid clamp.
  localparam logic signed [W+1:0] MaxX  = {3'b000, {(W - 1){1'b1}}};
  localparam logic signed [W+1:0] MinX  = {3'b111, {(W - 1){1'b0}}};
  localparam logic signed [W+1:0] HalfX = (W + 2)'(1 << (FRAC - 1));
  localparam logic signed [W+1:0] OneX  = (W + 2)'(1 << FRAC);

  localparam logic [2*W-1:0] PosLim = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic [2*W-1:0] NegLim = PosLim + 1'b1;

  typedef enum logic [2:0] {StIdle, StExec, StMulIter, StMulFix, StDone} state_e;

  state_e               state_q, state_d;
  logic                 start_prev_q;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [15:0]          lfsr_q, lfsr_d, lfsr_adv;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*W-1:0]       acc_q, acc_d, mcand_q, mcand_d;
  logic [W-1:0]         mplier_q, mplier_d;
  logic                 phase_q, phase_d;
  logic [W-1:0]         fix_q, fix_d;
  logic [W-1:0]         result_q, result_d;
  logic                 finished_q, finished_d;

  logic [3:0]           in_op, op, arg;
  logic [W-1:0]         in_a, in_b, abs_a, abs_b, op_a, op_b;
  logic signed [W+1:0]  a_x, b_x, sum_x, diff_x, sig_x, rnd_x, mut_x;
  logic [W-1:0]         exec_res, mul_fixed;
  logic [2*W-1:0]       shifted;
  logic                 accept;

  function automatic logic [W-1:0] sat(input logic signed [W+1:0] v);
    if (v > MaxX)      return MaxX[W-1:0];
    else if (v < MinX) return MinX[W-1:0];
    else               return v[W-1:0];
  endfunction

  assign in_op  = instruction_dp[INSTR_W-1 -: 4];
  assign in_a   = instruction_dp[2*W-1:W];
  assign in_b   = instruction_dp[W-1:0];
  assign abs_a  = in_a[W-1] ? -in_a : in_a;
  assign abs_b  = in_b[W-1] ? -in_b : in_b;
  assign accept = start_dp && !start_prev_q;

  assign op   = instr_q[INSTR_W-1 -: 4];
  assign arg  = instr_q[INSTR_W-5:2*W];
  assign op_a = instr_q[2*W-1:W];
  assign op_b = instr_q[W-1:0];

  // Galois right-shift LFSR, taps 0xB400.
  assign lfsr_adv = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    a_x      = {{2{op_a[W-1]}}, op_a};
    b_x      = {{2{op_b[W-1]}}, op_b};
    sum_x    = a_x + b_x;
    diff_x   = a_x - b_x;
    sig_x    = HalfX + (a_x >>> 2);
    rnd_x    = {{(W - 14){lfsr_q[15]}}, lfsr_q};
    mut_x    = a_x + (rnd_x >>> arg);
    exec_res = '0;
    case (op)
      OpAdd:    exec_res = sat(sum_x);
      OpSub:    exec_res = sat(diff_x);
      OpMax:    exec_res = ($signed(op_a) > $signed(op_b)) ? op_a : op_b;
      OpRelu:   exec_res = op_a[W-1] ? '0 : op_a;
      OpSigm: begin
        if (sig_x < 0)         exec_res = '0;
        else if (sig_x > OneX) exec_res = OneX[W-1:0];
        else                   exec_res = sig_x[W-1:0];
      end
      OpRand:   exec_res = W'(lfsr_q);
      OpMutate: exec_res = sat(mut_x);
      default:  exec_res = '0;
    endcase
  end

  // Magnitude product truncated toward zero, then signed and saturated.
  always_comb begin
    shifted = acc_q >> FRAC;
    if (op_a[W-1] ^ op_b[W-1]) begin
      mul_fixed = (shifted > NegLim) ? MinX[W-1:0] : -shifted[W-1:0];
    end else begin
      mul_fixed = (shifted > PosLim) ? MaxX[W-1:0] : shifted[W-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    phase_d    = phase_q;
    fix_d      = fix_q;
    result_d   = result_q;
    finished_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          instr_d = instruction_dp;
          if (in_op == OpRand || in_op == OpMutate) lfsr_d = lfsr_adv;
          if (in_op == OpMul) begin
            state_d  = StMulIter;
            cnt_d    = CntW'(W);
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, abs_a};
            mplier_d = abs_b;
          end else begin
            state_d = StExec;
            // Counter holds L-1; DONE is entered when it has reached zero.
            cnt_d   = (in_op == OpSigm || in_op == OpMutate) ? CntW'(2) : CntW'(1);
          end
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          state_d    = StDone;
          finished_d = 1'b1;
          result_d   = exec_res;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StMulIter: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StMulFix;
          phase_d = 1'b0;
        end
      end
      StMulFix: begin
        // First cycle registers the fixed-up product, second commits it.
        if (!phase_q) begin
          fix_d   = mul_fixed;
          phase_d = 1'b1;
        end else begin
          state_d    = StDone;
          finished_d = 1'b1;
          result_d   = fix_q;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b0;
      instr_q      <= '0;
      lfsr_q       <= SEED;
      cnt_q        <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      phase_q      <= 1'b0;
      fix_q        <= '0;
      result_q     <= '0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_dp;
      instr_q      <= instr_d;
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      phase_q      <= phase_d;
      fix_q        <= fix_d;
      result_q     <= result_d;
      finished_q   <= finished_d;
    end
  end

  assign result_dp   = result_q;
  assign finished_dp = finished_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_neuro_datapath.sv
// Directed scoreboard bench for neuro_datapath: results and latencies queued at issue,
// compared when finished_dp pulses.
module tb_neuro_datapath;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [39:0] instruction_dp = '0;
  logic        start_dp = 1'b0;
  logic [15:0] result_dp;
  logic        finished_dp;
  logic        busy;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  typedef struct {
    string       tag;
    logic [15:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];

  neuro_datapath dut (
    .clock          (clock),
    .resetn         (resetn),
    .instruction_dp (instruction_dp),
    .start_dp       (start_dp),
    .result_dp      (result_dp),
    .finished_dp    (finished_dp),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    start_dp = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  // Issue one instruction; start_dp held for `hold` accepted cycles, optional
  // extra rising edge on start while the op is in flight.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] arg,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_res, input int lat, input int hold,
                        input bit glitch);
    exp_t e;
    exp_t got_e;
    bit   got = 1'b0;
    e.tag = tag;
    e.res = exp_res;
    e.lat = lat;
    sb.push_back(e);
    @(negedge clock);
    instruction_dp = {op, arg, a, b};
    start_dp       = 1'b1;
    @(posedge clock);
    #1;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    if (hold <= 1) start_dp = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clock);
      #1;
      if (i >= hold - 1) start_dp = 1'b0;
      if (glitch && i == 2) start_dp = 1'b1;
      if (finished_dp) begin
        got   = 1'b1;
        got_e = sb.pop_front();
        chk({got_e.tag, ".res"}, 32'(result_dp), 32'(got_e.res));
        chk({got_e.tag, ".lat"}, 32'(i), 32'(got_e.lat));
      end
    end
    if (!got) begin
      got_e = sb.pop_front();
      chk({tag, ".timeout"}, 32'd0, 32'd1);
    end
    @(posedge clock);
    #1;
    chk({tag, ".pulse_end"}, 32'(finished_dp), 32'd0);
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int extra = 0;
    repeat (cycles) begin
      @(posedge clock);
      #1;
      if (finished_dp) extra++;
    end
    chk(tag, 32'(extra), 32'd0);
  endtask

  initial begin
    do_reset();
    chk("rst.result", 32'(result_dp), 32'd0);
    chk("rst.finished", 32'(finished_dp), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);

    run_op("add_hold", 4'd1, 4'd0, 16'h0180, 16'h0100, 16'h0280, 2, 2, 1'b0);
    quiet("add_hold.single", 5);
    run_op("add_sat",  4'd1, 4'd0, 16'h7F00, 16'h7F00, 16'h7FFF, 2, 1, 1'b0);
    run_op("sub_sat",  4'd2, 4'd0, 16'h8100, 16'h7F00, 16'h8000, 2, 1, 1'b0);
    run_op("mul_neg",  4'd3, 4'd0, 16'h0200, 16'hFE80, 16'hFD00, 18, 1, 1'b0);
    run_op("mul_sat",  4'd3, 4'd0, 16'h7F00, 16'h7F00, 16'h7FFF, 18, 1, 1'b0);
    run_op("mul_min",  4'd3, 4'd0, 16'h8000, 16'h0100, 16'h8000, 18, 1, 1'b0);
    run_op("sigm_0",   4'd6, 4'd0, 16'h0000, 16'h0000, 16'h0080, 3, 1, 1'b0);
    run_op("sigm_hi",  4'd6, 4'd0, 16'h0400, 16'h0000, 16'h0100, 3, 1, 1'b0);
    run_op("sigm_lo",  4'd6, 4'd0, 16'hFC00, 16'h0000, 16'h0000, 3, 1, 1'b0);
    run_op("relu_neg", 4'd5, 4'd0, 16'hFF00, 16'h0000, 16'h0000, 2, 1, 1'b0);
    run_op("max",      4'd4, 4'd0, 16'hFF00, 16'h0100, 16'h0100, 2, 1, 1'b0);
    run_op("nop",      4'd0, 4'd0, 16'h1234, 16'h4321, 16'h0000, 2, 1, 1'b0);
    run_op("op12",     4'd12, 4'd0, 16'h1234, 16'h4321, 16'h0000, 2, 1, 1'b0);

    do_reset();
    run_op("rand1", 4'd7, 4'd0, 16'h0000, 16'h0000, 16'hE270, 2, 1, 1'b0);
    run_op("rand2", 4'd7, 4'd0, 16'h0000, 16'h0000, 16'h7138, 2, 1, 1'b0);

    do_reset();
    run_op("mutate", 4'd8, 4'd15, 16'h0100, 16'h0000, 16'h00FF, 3, 1, 1'b0);

    run_op("mul_glitch", 4'd3, 4'd0, 16'h0200, 16'hFE80, 16'hFD00, 18, 1, 1'b1);
    quiet("glitch.no_second", 25);

    // Abort a multiply mid-flight with reset.
    @(negedge clock);
    instruction_dp = {4'd3, 4'd0, 16'h0200, 16'h0100};
    start_dp       = 1'b1;
    @(posedge clock);
    #1;
    start_dp = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    resetn = 1'b0;
    @(posedge clock);
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.result", 32'(result_dp), 32'd0);
    chk("abort.finished", 32'(finished_dp), 32'd0);
    resetn = 1'b1;
    quiet("abort.no_pulse", 25);
    run_op("after_abort", 4'd1, 4'd0, 16'h0100, 16'h0100, 16'h0200, 2, 1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/neuro_datapath.md
Name: neuro_datapath

Overview:
Shared single-issue fixed-point execution unit sitting directly downstream of the datapath router. It accepts one instruction per start handshake, executes it (add, multiply, activation, random and mutation ops used by neuroevolution threads) with op-dependent latency, and returns a result with a one-cycle finished pulse. It is stateless across instructions except for an internal LFSR, so the router may interleave threads freely.

Parameters:
W, 16, operand/result width (signed two's complement)
FRAC, 8, fractional bits (Q(W-FRAC).FRAC)
SEED, 16'hACE1, LFSR reset value; must be nonzero
INSTR_W, 2*W+8, instruction width

Ports:
clock  input  1  system clock
resetn  input  1  synchronous active-low reset
instruction_dp  input  INSTR_W  [INSTR_W-1:INSTR_W-4] opcode, [INSTR_W-5:2W] arg (shift amount), [2W-1:W] operand A, [W-1:0] operand B
start_dp  input  1  request level; a rising edge while IDLE launches an instruction
result_dp  output  W  result; valid with finished_dp, held until next acceptance
finished_dp  output  1  one-cycle completion pulse
busy  output  1  high from accepting edge until the edge that ends the finished pulse

Behaviour:
- Reset: resetn is synchronous, active-low, on clock. result_dp=0, finished_dp=0, busy=0, state=IDLE, start_prev=0, LFSR=SEED. Reset mid-operation aborts the instruction with no finished pulse.
- Acceptance: at an edge where state==IDLE, start_dp==1 and start_prev==0. instruction_dp is latched at that edge. start_dp held high for several cycles counts once. A rising edge in any other state is ignored, not queued.
- States:
  - IDLE -> EXEC on acceptance; MUL goes to MUL_ITER instead.
  - EXEC -> DONE after (L-1) cycles.
  - MUL_ITER runs W iterations -> MUL_FIX -> DONE.
  - DONE lasts exactly one cycle: finished_dp=1, result_dp updated in the same cycle. DONE -> IDLE unconditionally.
- Latency L: finished_dp is high in the cycle following the L-th rising edge after the accepting edge. Minimum L=2, so the router sees start deasserted before finished.
- Opcodes and latency:
  - 0 NOP -> 0, L=2.
  - 1 ADD A+B, L=2.
  - 2 SUB A-B, L=2.
  - 3 MUL A*B, L=W+2.
  - 4 MAX signed max(A,B), L=2.
  - 5 RELU A<0?0:A, L=2.
  - 6 SIGM clamp(0.5+A/4, 0, 1.0), i.e. (1<<(FRAC-1)) + (A>>>2) clamped to [0, 1<<FRAC], L=3.
  - 7 RAND -> LFSR value after advance, L=2.
  - 8 MUTATE -> sat(A + ($signed(lfsr_next)>>>arg)), L=3.
  - 9..15 behave as NOP.
- Arithmetic:
  - All add/sub results saturate to [-(2^(W-1)), 2^(W-1)-1]; no wrap.
  - MUL: shift-add on magnitudes over W iterations, 2W-bit product; shift right FRAC (truncate magnitude toward zero); apply sign; saturate. -(2^(W-1)) magnitude handled correctly.
- LFSR: 16-bit Galois, right shift, tap mask 0xB400. It advances exactly once per accepted RAND or MUTATE, at the accepting edge, and never otherwise.
- busy is high from the accepting edge through the DONE cycle.

Test Plan:
- Reset, then ADD A=0x0180 B=0x0100 with start_dp held 2 cycles -> exactly one finished pulse, 2 cycles after accept, result 0x0280; busy drops after it.
- ADD 0x7F00+0x7F00 -> 0x7FFF; SUB 0x8100-0x7F00 -> 0x8000 (saturation both ends).
- MUL A=0x0200 B=0xFE80 -> 0xFD00 at L=18; MUL 0x7F00*0x7F00 -> 0x7FFF; MUL 0x8000*0x0100 -> 0x8000.
- SIGM A=0x0000 -> 0x0080; A=0x0400 -> 0x0100; A=0xFC00 -> 0x0000; RELU 0xFF00 -> 0x0000, all at the listed L.
- After reset, RAND -> 0xE270; a second RAND -> 0x7138. MUTATE A=0x0100 arg=15 on fresh reset -> 0x00FF, since lfsr_next=0xE270 and 0xE270>>>15 = -1.
- Assert resetn=0 mid-MUL at cycle 5 -> no finished pulse, result 0, busy 0. A new start edge after release is accepted normally; a start edge during EXEC is ignored (single pulse only).
